// File: rtl/alu_exec_pkg.sv
// Shared definitions for the ALU execute controller: FSM states, opcodes and
// instruction field positions.
package alu_exec_pkg;

   localparam int DATA_W = 16;
   localparam int RIDX_W = 3;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FETCH     = 3'd1,
      S_DECODE    = 3'd2,
      S_EXECUTE   = 3'd3,
      S_WRITEBACK = 3'd4,
      S_HALTED    = 3'd5
   } state_e;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_MUL  = 4'd2;
   localparam logic [3:0] OP_DIV  = 4'd3;
   localparam logic [3:0] OP_MOD  = 4'd4;
   localparam logic [3:0] OP_AND  = 4'd5;
   localparam logic [3:0] OP_OR   = 4'd6;
   localparam logic [3:0] OP_XOR  = 4'd7;
   localparam logic [3:0] OP_CLR  = 4'd8;
   localparam logic [3:0] OP_SHL  = 4'd9;
   localparam logic [3:0] OP_SHR  = 4'd10;
   localparam logic [3:0] OP_NOT  = 4'd11;
   localparam logic [3:0] OP_LDI  = 4'd12;
   localparam logic [3:0] OP_NOP  = 4'd13;
   localparam logic [3:0] OP_ILL  = 4'd14;
   localparam logic [3:0] OP_HALT = 4'd15;

   localparam int OPC_HI = 15;
   localparam int OPC_LO = 12;
   localparam int RD_HI  = 11;
   localparam int RD_LO  = 9;
   localparam int RS1_HI = 8;
   localparam int RS1_LO = 6;
   localparam int RS2_HI = 5;
   localparam int RS2_LO = 3;
   localparam int IMM_HI = 8;
   localparam int IMM_LO = 0;

   function automatic logic is_alu_op(input logic [3:0] op);
      return op <= OP_NOT;
   endfunction

endpackage

// File: rtl/alu_exec_ctrl_reg_file.sv
// 8x16 register file: two operand read ports, one debug read port and a single
// synchronous write port, cleared by the asynchronous reset.
module reg_file
   import alu_exec_pkg::*;
#(
   parameter int NREG = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we_i,
   input  logic [RIDX_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [RIDX_W-1:0] raddr1_i,
   input  logic [RIDX_W-1:0] raddr2_i,
   input  logic [RIDX_W-1:0] dbg_addr_i,
   output logic [DATA_W-1:0] rdata1_o,
   output logic [DATA_W-1:0] rdata2_o,
   output logic [DATA_W-1:0] dbg_data_o
);

   logic [NREG-1:0][DATA_W-1:0] regs_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs_q <= '0;
      end else if (we_i) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   // No write bypass: a read in the write cycle returns the old value.
   assign rdata1_o   = regs_q[raddr1_i];
   assign rdata2_o   = regs_q[raddr2_i];
   assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_exec_ctrl.sv
// Multi-cycle fetch/decode/execute/writeback controller around the 16-bit ALU.
// Optional RETIRE_CNT_EN adds a saturating retire_cnt output.
module alu_exec_ctrl
   import alu_exec_pkg::*;
#(
   parameter int PC_W = 8,
   parameter int NREG = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              imem_req,
   output logic [PC_W-1:0]   imem_addr,
   input  logic              imem_ready,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic [3:0]        alu_op,
   output logic [DATA_W-1:0] alu_in1,
   output logic [DATA_W-1:0] alu_in2,
   input  logic [DATA_W-1:0] alu_z,
   output logic              busy,
   output logic              halted,
   output logic              err_illegal,
   output logic              err_div0,
   input  logic [RIDX_W-1:0] dbg_rd_addr,
   output logic [DATA_W-1:0] dbg_rd_data
`ifdef RETIRE_CNT_EN
   ,
   output logic [15:0]       retire_cnt
`endif
);

   state_e            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [DATA_W-1:0] ir_q, ir_d;
   logic [DATA_W-1:0] res_q, res_d;
   logic              wsup_q, wsup_d;
   logic [3:0]        alu_op_q, alu_op_d;
   logic [DATA_W-1:0] in1_q, in1_d;
   logic [DATA_W-1:0] in2_q, in2_d;
   logic              ill_q, ill_d;
   logic              dz_q, dz_d;

   logic              rf_we;
   logic [DATA_W-1:0] rf_wdata;
   logic [DATA_W-1:0] rs1_data, rs2_data;
   logic [3:0]        opc;
   logic              div_like;

   assign opc      = ir_q[OPC_HI:OPC_LO];
   assign div_like = (alu_op_q == OP_DIV) || (alu_op_q == OP_MOD);

   reg_file #(.NREG(NREG)) u_rf (
      .clk        (clk),
      .rst_n      (rst_n),
      .we_i       (rf_we),
      .waddr_i    (ir_q[RD_HI:RD_LO]),
      .wdata_i    (rf_wdata),
      .raddr1_i   (ir_q[RS1_HI:RS1_LO]),
      .raddr2_i   (ir_q[RS2_HI:RS2_LO]),
      .dbg_addr_i (dbg_rd_addr),
      .rdata1_o   (rs1_data),
      .rdata2_o   (rs2_data),
      .dbg_data_o (dbg_rd_data)
   );

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      res_d    = res_q;
      wsup_d   = wsup_q;
      alu_op_d = alu_op_q;
      in1_d    = in1_q;
      in2_d    = in2_q;
      ill_d    = ill_q;
      dz_d     = dz_q;
      rf_we    = 1'b0;
      rf_wdata = res_q;
      case (state_q)
         S_IDLE, S_HALTED: begin
            if (start) begin
               pc_d    = '0;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            if (imem_ready) begin
               ir_d    = imem_rdata;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (is_alu_op(opc)) begin
               alu_op_d = opc;
               in1_d    = rs1_data;
               in2_d    = rs2_data;
               state_d  = S_EXECUTE;
            end else if (opc == OP_LDI || opc == OP_NOP) begin
               state_d = S_WRITEBACK;
            end else if (opc == OP_HALT) begin
               state_d = S_HALTED;
            end else begin
               ill_d   = 1'b1;
               state_d = S_HALTED;
            end
         end
         S_EXECUTE: begin
            // CLR is defined to produce zero regardless of what the ALU returns.
            res_d  = (alu_op_q == OP_CLR) ? '0 : alu_z;
            wsup_d = div_like && (in2_q == '0);
            if (div_like && (in2_q == '0)) dz_d = 1'b1;
            state_d = S_WRITEBACK;
         end
         S_WRITEBACK: begin
            if (opc == OP_LDI) begin
               rf_we    = 1'b1;
               rf_wdata = {{(DATA_W-IMM_HI-1){1'b0}}, ir_q[IMM_HI:IMM_LO]};
            end else if (is_alu_op(opc) && !wsup_q) begin
               rf_we    = 1'b1;
               rf_wdata = res_q;
            end
            pc_d    = pc_q + PC_W'(1);
            state_d = S_FETCH;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         pc_q     <= '0;
         ir_q     <= '0;
         res_q    <= '0;
         wsup_q   <= 1'b0;
         alu_op_q <= '0;
         in1_q    <= '0;
         in2_q    <= '0;
         ill_q    <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         res_q    <= res_d;
         wsup_q   <= wsup_d;
         alu_op_q <= alu_op_d;
         in1_q    <= in1_d;
         in2_q    <= in2_d;
         ill_q    <= ill_d;
         dz_q     <= dz_d;
      end
   end

`ifdef RETIRE_CNT_EN
   logic [15:0] retire_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retire_q <= '0;
      end else if (state_q == S_WRITEBACK && retire_q != 16'hFFFF) begin
         retire_q <= retire_q + 16'd1;
      end
   end

   assign retire_cnt = retire_q;
`endif

   assign imem_req    = (state_q == S_FETCH);
   assign imem_addr   = pc_q;
   assign alu_op      = alu_op_q;
   assign alu_in1     = in1_q;
   assign alu_in2     = in2_q;
   assign busy        = (state_q != S_IDLE) && (state_q != S_HALTED);
   assign halted      = (state_q == S_HALTED);
   assign err_illegal = ill_q;
   assign err_div0    = dz_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Scoreboard bench for alu_exec_ctrl: directed programs, expectations checked
// by a monitor each time the controller reaches HALTED.
module tb_alu_exec_ctrl;
   import alu_exec_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic        imem_ready = 1'b0;
   logic [15:0] imem_rdata = '0;
   logic [3:0]  alu_op;
   logic [15:0] alu_in1, alu_in2, alu_z;
   logic        busy, halted, err_illegal, err_div0;
   logic [2:0]  dbg_rd_addr = '0;
   logic [15:0] dbg_rd_data;
`ifdef RETIRE_CNT_EN
   logic [15:0] retire_cnt;
`endif

   alu_exec_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rdata  (imem_rdata),
      .alu_op      (alu_op),
      .alu_in1     (alu_in1),
      .alu_in2     (alu_in2),
      .alu_z       (alu_z),
      .busy        (busy),
      .halted      (halted),
      .err_illegal (err_illegal),
      .err_div0    (err_div0),
      .dbg_rd_addr (dbg_rd_addr),
      .dbg_rd_data (dbg_rd_data)
`ifdef RETIRE_CNT_EN
      ,
      .retire_cnt  (retire_cnt)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Stand-in ALU; opcode 8 deliberately returns junk so the controller's zeroing shows.
   always_comb begin
      alu_z = '0;
      case (alu_op)
         4'd0:  alu_z = alu_in1 + alu_in2;
         4'd1:  alu_z = alu_in1 - alu_in2;
         4'd2:  alu_z = alu_in1 * alu_in2;
         4'd3:  alu_z = (alu_in2 == 0) ? 16'hFFFF : alu_in1 / alu_in2;
         4'd4:  alu_z = (alu_in2 == 0) ? alu_in1 : alu_in1 % alu_in2;
         4'd5:  alu_z = alu_in1 & alu_in2;
         4'd6:  alu_z = alu_in1 | alu_in2;
         4'd7:  alu_z = alu_in1 ^ alu_in2;
         4'd8:  alu_z = alu_in1 ^ 16'hA5A5;
         4'd9:  alu_z = alu_in1 << alu_in2[3:0];
         4'd10: alu_z = alu_in1 >> alu_in2[3:0];
         4'd11: alu_z = ~alu_in1;
         default: alu_z = '0;
      endcase
   end

   int n_pass = 0, n_total = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Instruction memory with programmable wait states
   logic [15:0] prog [256];
   int          mem_delay = 0;

   initial begin
      int         wcnt;
      logic [7:0] held;
      wcnt = 0;
      held = '0;
      forever begin
         @(negedge clk);
         if (!imem_req || imem_ready) begin
            imem_ready = 1'b0;
            wcnt = 0;
         end else if (wcnt == mem_delay) begin
            if (wcnt > 0) chk("fetch_addr_stable", imem_addr, held);
            imem_ready = 1'b1;
            imem_rdata = prog[imem_addr];
         end else begin
            if (wcnt > 0) chk("fetch_addr_stable", imem_addr, held);
            held = imem_addr;
            wcnt++;
         end
      end
   end

   typedef struct {
      int               cycles;
      logic [7:0]       pc;
      logic             ill;
      logic             dz;
      logic [7:0][15:0] regs;
   } exp_t;

   exp_t sbq[$];
   int   n_halt = 0;
   int   t0 = 0;

   // Monitor: every entry into HALTED pops one expectation.
   initial begin
      exp_t e;
      logic prev_h;
      int   el;
      prev_h = 1'b0;
      forever begin
         @(negedge clk);
         if (halted && !prev_h) begin
            el = cyc - t0;
            if (sbq.size() == 0) begin
               chk("unexpected_halt", 32'd1, 32'd0);
            end else begin
               e = sbq.pop_front();
               chk("halt_cycles", el, e.cycles);
               chk("halt_pc", imem_addr, e.pc);
               chk("err_illegal", err_illegal, e.ill);
               chk("err_div0", err_div0, e.dz);
               chk("busy_halted", busy, 1'b0);
               for (int r = 0; r < 8; r++) begin
                  dbg_rd_addr = 3'(r);
                  #1;
                  chk($sformatf("R%0d", r), dbg_rd_data, e.regs[r]);
               end
            end
            n_halt++;
         end
         prev_h = halted;
      end
   end

   function automatic logic [15:0] alu_i(input logic [3:0] op, input int rd, input int rs1, input int rs2);
      return {op, 3'(rd), 3'(rs1), 3'(rs2), 3'b000};
   endfunction

   function automatic logic [15:0] ldi(input int rd, input int imm);
      return {OP_LDI, 3'(rd), 9'(imm)};
   endfunction

   task automatic clear_prog();
      for (int i = 0; i < 256; i++) prog[i] = {OP_HALT, 12'h000};
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      t0 = cyc;
   endtask

   task automatic run(input int cycles, input logic [7:0] pc, input logic ill, input logic dz,
                      input logic [7:0][15:0] regs);
      exp_t e;
      int   h0;
      e.cycles = cycles;
      e.pc     = pc;
      e.ill    = ill;
      e.dz     = dz;
      e.regs   = regs;
      sbq.push_back(e);
      h0 = n_halt;
      pulse_start();
      for (int i = 0; i < 400 && n_halt == h0; i++) @(negedge clk);
      if (n_halt == h0) begin
         chk("halt_timeout", 32'd0, 32'd1);
         sbq.delete();
      end
   endtask

   task automatic load_t1();
      clear_prog();
      prog[0] = ldi(1, 5);
      prog[1] = ldi(2, 3);
      prog[2] = alu_i(OP_ADD, 3, 1, 2);
   endtask

   logic [7:0][15:0] er;

   initial begin
      er = '0;
      clear_prog();
      #2;
      chk("rst_busy", busy, 1'b0);
      chk("rst_halted", halted, 1'b0);
      chk("rst_err_illegal", err_illegal, 1'b0);
      chk("rst_err_div0", err_div0, 1'b0);
      chk("rst_imem_req", imem_req, 1'b0);
      chk("rst_alu_op", alu_op, 4'd0);
      chk("rst_alu_in1", alu_in1, 16'd0);
      chk("rst_alu_in2", alu_in2, 16'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // LDI, LDI, ADD, HALT with zero-wait memory
      load_t1();
      er[1] = 16'd5; er[2] = 16'd3; er[3] = 16'd8;
      run(12, 8'd3, 1'b0, 1'b0, er);

      // SUB wraps negative, MUL
      clear_prog();
      prog[0] = alu_i(OP_SUB, 4, 2, 1);
      prog[1] = alu_i(OP_MUL, 5, 1, 1);
      er[4] = 16'hFFFE; er[5] = 16'd25;
      run(10, 8'd2, 1'b0, 1'b0, er);

      // Divide by zero suppression, 9-bit LDI, CLR, back-to-back hazard, NOT, NOP
      clear_prog();
      prog[0] = ldi(1, 7);
      prog[1] = ldi(2, 16'h55);
      prog[2] = alu_i(OP_DIV, 2, 1, 0);
      prog[3] = ldi(6, 16'h1FF);
      prog[4] = alu_i(OP_CLR, 6, 1, 1);
      prog[5] = alu_i(OP_ADD, 7, 1, 1);
      prog[6] = alu_i(OP_ADD, 7, 7, 7);
      prog[7] = alu_i(OP_NOT, 4, 1, 0);
      prog[8] = {OP_NOP, 12'h000};
      prog[9] = {OP_HALT, 12'h000};
      er[1] = 16'd7; er[2] = 16'h0055; er[6] = 16'h0000; er[7] = 16'd28; er[4] = 16'hFFF8;
      run(34, 8'd9, 1'b0, 1'b1, er);

      // Illegal opcode at PC 0, then restart keeps the sticky flag
      clear_prog();
      prog[0] = 16'hE000;
      run(2, 8'd0, 1'b1, 1'b1, er);
      load_t1();
      er[1] = 16'd5; er[2] = 16'd3; er[3] = 16'd8;
      run(12, 8'd3, 1'b1, 1'b1, er);

      // Three wait states on every fetch
      mem_delay = 3;
      run(24, 8'd3, 1'b1, 1'b1, er);
      mem_delay = 0;

      // Reset asserted during EXECUTE of the ADD
      pulse_start();
      repeat (8) @(posedge clk);
      #2;
      chk("pre_rst_alu_in1", alu_in1, 16'd5);
      chk("pre_rst_busy", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_imem_req", imem_req, 1'b0);
      chk("mid_rst_alu_in1", alu_in1, 16'd0);
      chk("mid_rst_alu_in2", alu_in2, 16'd0);
      chk("mid_rst_err_illegal", err_illegal, 1'b0);
      chk("mid_rst_err_div0", err_div0, 1'b0);
`ifdef RETIRE_CNT_EN
      chk("mid_rst_retire_cnt", retire_cnt, 16'd0);
`endif
      for (int r = 0; r < 8; r++) begin
         dbg_rd_addr = 3'(r);
         #0.1;
         chk($sformatf("mid_rst_R%0d", r), dbg_rd_data, 16'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      clear_prog();
      er = '0;
      run(2, 8'd0, 1'b0, 1'b0, er);
`ifdef RETIRE_CNT_EN
      chk("retire_cnt_after_halt_only", retire_cnt, 16'd0);
`endif

      chk("scoreboard_empty", sbq.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

endmodule
